// File: rtl/alu_serial_addsub_pkg.sv
// alu_serial_pkg: shared state, op and counter types for the nibble-serial add/sub unit
package alu_serial_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef logic [7:0] nib_cnt_t;
endpackage

// File: rtl/alu_serial_addsub_adder4.sv
// Adder4: 4-bit carry-lookahead adder slice
module Adder4 (
  input  logic       c0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  output logic [3:0] sout,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;
  always_comb begin
    g = in1 & in2;
    p = in1 ^ in2;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    sout = p ^ c[3:0];
    cout = c[4];
  end
endmodule

// File: rtl/alu_serial_addsub.sv
// alu_serial_addsub: multi-cycle add/subtract, one nibble per cycle LSB first
module alu_serial_addsub
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);
  localparam int NIB = WIDTH / 4;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic c_q, c_d, carry_q, carry_d, overflow_q, overflow_d, zero_q, zero_d;
  nib_cnt_t cnt_q, cnt_d;
  logic [3:0] a_nib, b_nib, sum;
  logic cout, last;
  assign a_nib = 4'(a_q >> {cnt_q, 2'b00});
  assign b_nib = 4'(b_q >> {cnt_q, 2'b00});
  assign last = cnt_q == nib_cnt_t'(NIB - 1);
  Adder4 u_add (.c0(c_q), .in1(a_nib), .in2(b_nib), .sout(sum), .cout(cout));
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result = result_q;
  assign carry = carry_q;
  assign overflow = overflow_q;
  assign zero = zero_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    cnt_d = cnt_q;
    result_d = result_q;
    carry_d = carry_q;
    overflow_d = overflow_q;
    zero_d = zero_q;
    if (state_q == IDLE && in_valid) begin
      a_d = a;
      b_d = op_sub == OP_SUB ? ~b : b;
      c_d = op_sub;
      cnt_d = '0;
      result_d = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      // result is cleared on accept, so OR-ing each nibble into place is enough
      result_d = result_q | (WIDTH'(sum) << {cnt_q, 2'b00});
      c_d = cout;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      if (last) begin
        carry_d = cout;
        overflow_d = sum[3] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ cout;
        zero_d = result_d == '0;
        state_d = DONE;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= 1'b0;
      cnt_q <= '0;
      result_q <= '0;
      carry_q <= 1'b0;
      overflow_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      cnt_q <= cnt_d;
      result_q <= result_d;
      carry_q <= carry_d;
      overflow_q <= overflow_d;
      zero_q <= zero_d;
    end
  end
endmodule
